// File: rtl/unified_mem_ctrl_if.sv
// Shared bus between a core and the unified memory controller:
// an instruction-fetch port and a load/store data port.
interface unified_mem_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_funct3, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_err
  );

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_funct3, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_err
  );
endinterface

// File: rtl/unified_mem_ctrl.sv
// Single-port word memory shared by instruction fetch and data load/store,
// with alternating arbitration and a fixed one-cycle response.
module unified_mem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  unified_mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_RESP = 2'd1,
    D_RESP = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic              last_d_reg;
  logic              if_gnt_c;
  logic              d_gnt_c;
  logic              any_gnt;

  logic [1:0]        lane;
  logic              f3_legal;
  logic              misalign;
  logic              d_err_c;
  logic [3:0]        byte_en;
  logic [31:0]       wr_data;
  logic              mem_we;
  logic [3:0]        lane_we;
  logic [IDX_W-1:0]  mem_idx;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       rd_word_reg;

  logic [2:0]        f3_reg;
  logic [1:0]        lane_reg;
  logic              ld_ok_reg;
  logic              err_reg;
  logic [31:0]       if_hold_reg;
  logic [31:0]       d_hold_reg;

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       ld_ext;
  logic [31:0]       d_ext;

  logic              unused_addr_bits;

  // Data wins a collision unless it won the previous cycle; reset blocks all grants.
  assign d_gnt_c  = reset & bus.d_req & (~bus.if_req | ~last_d_reg);
  assign if_gnt_c = reset & bus.if_req & ~d_gnt_c;
  assign any_gnt  = d_gnt_c | if_gnt_c;

  assign bus.d_gnt  = d_gnt_c;
  assign bus.if_gnt = if_gnt_c;

  assign lane = bus.d_addr[1:0];

  always_comb begin
    f3_legal = 1'b0;
    case (bus.d_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~bus.d_we;
      default:                f3_legal = 1'b0;
    endcase
    misalign = 1'b0;
    case (bus.d_funct3[1:0])
      2'b01:   misalign = lane[0];
      2'b10:   misalign = |lane;
      default: misalign = 1'b0;
    endcase
  end

  assign d_err_c = ~f3_legal | misalign;

  // Store data is replicated across lanes so each byte enable sees its own slice.
  always_comb begin
    byte_en = 4'b1111;
    wr_data = bus.d_wdata;
    case (bus.d_funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << lane;
        wr_data = {4{bus.d_wdata[7:0]}};
      end
      2'b01: begin
        byte_en = 4'b0011 << {lane[1], 1'b0};
        wr_data = {2{bus.d_wdata[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wr_data = bus.d_wdata;
      end
    endcase
  end

  assign mem_we = d_gnt_c & bus.d_we & ~d_err_c;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
      assign lane_we[gi] = mem_we & byte_en[gi];
    end
  endgenerate

  assign mem_idx = d_gnt_c ? bus.d_addr[IDX_W+1:2] : bus.if_addr[IDX_W+1:2];

  assign unused_addr_bits = ^{bus.if_addr[31:IDX_W+2], bus.if_addr[1:0],
                              bus.d_addr[31:IDX_W+2]};

  // One shared address per cycle; contents are never touched by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) begin
        mem[mem_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
    if (any_gnt) begin
      rd_word_reg <= mem[mem_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      last_d_reg  <= 1'b0;
      f3_reg      <= 3'b010;
      lane_reg    <= 2'b00;
      ld_ok_reg   <= 1'b0;
      err_reg     <= 1'b0;
      if_hold_reg <= 32'h0;
      d_hold_reg  <= 32'h0;
    end else begin
      state_reg   <= state_next;
      last_d_reg  <= d_gnt_c;
      if_hold_reg <= bus.if_rdata;
      d_hold_reg  <= bus.d_rdata;
      if (d_gnt_c) begin
        f3_reg    <= bus.d_funct3;
        lane_reg  <= lane;
        ld_ok_reg <= ~bus.d_we & ~d_err_c;
        err_reg   <= d_err_c;
      end
    end
  end

  always_comb begin
    state_next = IDLE;
    if (if_gnt_c) begin
      state_next = I_RESP;
    end else if (d_gnt_c) begin
      state_next = D_RESP;
    end
  end

  assign byte_sel = rd_word_reg[{lane_reg, 3'b000} +: 8];
  assign half_sel = rd_word_reg[{lane_reg[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = rd_word_reg;
    case (f3_reg)
      3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ld_ext = {24'h0, byte_sel};
      3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  ld_ext = {16'h0, half_sel};
      default: ld_ext = rd_word_reg;
    endcase
  end

  assign d_ext = ld_ok_reg ? ld_ext : 32'h0;

  // Outside a response cycle the data buses replay their last delivered value.
  assign bus.if_rvalid = (state_reg == I_RESP);
  assign bus.d_rvalid  = (state_reg == D_RESP);
  assign bus.if_rdata  = (state_reg == I_RESP) ? rd_word_reg : if_hold_reg;
  assign bus.d_rdata   = (state_reg == D_RESP) ? d_ext : d_hold_reg;
  assign bus.d_err     = (state_reg == D_RESP) & err_reg;

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Directed and random checks of unified_mem_ctrl against a byte-addressed
// reference memory.
module tb_unified_mem_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  unified_mem_ctrl_if bus ();

  unified_mem_ctrl #(.DEPTH_WORDS(256), .IDX_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] ref_mem [1024];
  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || ((a % nbytes(f3)) != 0);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'(a[9:2]) * 4;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(f3);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a[9:0]) + i]) << (8 * i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < nbytes(f3); i++) ref_mem[int'(a[9:0]) + i] = wd[8*i +: 8];
  endtask

  task automatic d_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag, output logic [31:0] got);
    bit          e_err;
    logic [31:0] e_data;
    int          waited;
    e_err  = ref_err(we, f3, addr);
    e_data = (we || e_err) ? 32'h0 : ref_load(f3, addr);
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_funct3 = f3; bus.d_addr = addr; bus.d_wdata = wdata;
    #1;
    waited = 0;
    while (bus.d_gnt !== 1'b1 && waited < 8) begin
      @(negedge clk); #1; waited++;
    end
    chk({tag, "_gnt"}, 32'(bus.d_gnt), 32'd1);
    if (we && !e_err) ref_store(f3, addr, wdata);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    chk({tag, "_rvalid"}, 32'(bus.d_rvalid), 32'd1);
    chk({tag, "_err"}, 32'(bus.d_err), 32'(e_err));
    chk({tag, "_rdata"}, bus.d_rdata, e_data);
    got = bus.d_rdata;
    $display("data we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d", we, f3, addr, wdata,
             bus.d_rdata, bus.d_err);
  endtask

  task automatic f_access(input logic [31:0] addr, input string tag, output logic [31:0] got);
    logic [31:0] e_data;
    int          waited;
    e_data = ref_word(addr);
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = addr;
    #1;
    waited = 0;
    while (bus.if_gnt !== 1'b1 && waited < 8) begin
      @(negedge clk); #1; waited++;
    end
    chk({tag, "_gnt"}, 32'(bus.if_gnt), 32'd1);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    chk({tag, "_rvalid"}, 32'(bus.if_rvalid), 32'd1);
    chk({tag, "_rdata"}, bus.if_rdata, e_data);
    got = bus.if_rdata;
    $display("fetch addr=%h -> rdata=%h", addr, bus.if_rdata);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_if_gnt"}, 32'(bus.if_gnt), 32'd0);
    chk({tag, "_d_gnt"}, 32'(bus.d_gnt), 32'd0);
    chk({tag, "_if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
    chk({tag, "_d_rvalid"}, 32'(bus.d_rvalid), 32'd0);
    chk({tag, "_d_err"}, 32'(bus.d_err), 32'd0);
    chk({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
    chk({tag, "_d_rdata"}, bus.d_rdata, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] e_d, e_i;
    logic [31:0] r_addr, r_wd;
    logic [2:0]  r_f3;

    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_funct3 = 3'b010;
    bus.d_addr = 32'h0; bus.d_wdata = 32'h1234_5678;
    reset = 1'b0;
    #2;
    chk_idle_outputs("reset");
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset_held");
    bus.d_req = 1'b0;
    reset = 1'b1;

    // Give every word a known value.
    for (int w = 0; w < 256; w++) d_access(1'b1, 3'b010, 32'(w * 4), $urandom, "preload", got);

    d_access(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, "sw_10", got);
    d_access(1'b0, 3'b010, 32'h10, 32'h0, "lw_10", got);
    chk("lw_10_lit", got, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("hold_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    chk("hold_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);

    d_access(1'b1, 3'b010, 32'h10, 32'h0, "sw_zero", got);
    d_access(1'b1, 3'b000, 32'h11, 32'h0000_007F, "sb_7f", got);
    d_access(1'b0, 3'b000, 32'h11, 32'h0, "lb_7f", got);
    chk("lb_7f_lit", got, 32'h0000_007F);
    d_access(1'b1, 3'b000, 32'h11, 32'h0000_0080, "sb_80", got);
    d_access(1'b0, 3'b000, 32'h11, 32'h0, "lb_80", got);
    chk("lb_80_lit", got, 32'hFFFF_FF80);
    d_access(1'b0, 3'b100, 32'h11, 32'h0, "lbu_80", got);
    chk("lbu_80_lit", got, 32'h0000_0080);
    d_access(1'b0, 3'b010, 32'h10, 32'h0, "lw_word", got);
    chk("lw_word_lit", got, 32'h0000_8000);

    d_access(1'b0, 3'b010, 32'h12, 32'h0, "lw_mis", got);
    d_access(1'b1, 3'b001, 32'h13, 32'hFFFF_FFFF, "sh_mis", got);
    d_access(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, "sbu_illegal", got);
    d_access(1'b0, 3'b011, 32'h10, 32'h0, "ld_f3_011", got);
    d_access(1'b0, 3'b110, 32'h10, 32'h0, "ld_f3_110", got);
    d_access(1'b0, 3'b010, 32'h10, 32'h0, "lw_after_err", got);
    chk("lw_after_err_lit", got, 32'h0000_8000);
    d_access(1'b1, 3'b001, 32'h16, 32'h0000_ABCD, "sh_hi", got);
    d_access(1'b0, 3'b001, 32'h16, 32'h0, "lh_hi", got);
    chk("lh_hi_lit", got, 32'hFFFF_ABCD);
    d_access(1'b0, 3'b101, 32'h16, 32'h0, "lhu_hi", got);
    chk("lhu_hi_lit", got, 32'h0000_ABCD);

    d_access(1'b1, 3'b010, 32'h0, 32'hA5A5_0001, "sw_0", got);
    f_access(32'h400, "fetch_wrap", got);
    chk("fetch_wrap_lit", got, 32'hA5A5_0001);
    @(posedge clk); #1;
    chk("hold_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("hold_if_rdata", bus.if_rdata, 32'hA5A5_0001);

    // Both ports requesting for four cycles after an idle cycle.
    @(negedge clk);
    @(negedge clk);
    e_d = ref_load(3'b010, 32'h10);
    e_i = ref_word(32'h20);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_funct3 = 3'b010; bus.d_addr = 32'h10;
    bus.if_req = 1'b1; bus.if_addr = 32'h20;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("alt%0d_d_gnt", k), 32'(bus.d_gnt), 32'((k % 2) == 0));
      chk($sformatf("alt%0d_if_gnt", k), 32'(bus.if_gnt), 32'((k % 2) == 1));
      @(posedge clk); #1;
      chk($sformatf("alt%0d_d_rvalid", k), 32'(bus.d_rvalid), 32'((k % 2) == 0));
      chk($sformatf("alt%0d_if_rvalid", k), 32'(bus.if_rvalid), 32'((k % 2) == 1));
      if ((k % 2) == 0) chk($sformatf("alt%0d_d_rdata", k), bus.d_rdata, e_d);
      else              chk($sformatf("alt%0d_if_rdata", k), bus.if_rdata, e_i);
      $display("arb cycle %0d: d_rvalid=%0d if_rvalid=%0d", k, bus.d_rvalid, bus.if_rvalid);
    end
    bus.d_req = 1'b0; bus.if_req = 1'b0;

    // Reset lands in the grant cycle of a store.
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_funct3 = 3'b010;
    bus.d_addr = 32'h20; bus.d_wdata = 32'h0000_0055;
    #1;
    reset = 1'b0;
    #1;
    chk_idle_outputs("rst_store");
    @(posedge clk); #1;
    chk_idle_outputs("rst_store_edge");
    @(negedge clk);
    bus.d_req = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_store_no_rvalid", 32'(bus.d_rvalid), 32'd0);
    $display("reset during store grant");
    d_access(1'b0, 3'b010, 32'h20, 32'h0, "lw_20_after_rst", got);

    // Reset lands while a load response is being delivered.
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_funct3 = 3'b010; bus.d_addr = 32'h10;
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_resp_dropped", 32'(bus.d_rvalid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_resp_not_late", 32'(bus.d_rvalid), 32'd0);
    $display("reset during load response");

    for (int n = 0; n < 120; n++) begin
      r_addr = $urandom;
      r_wd   = $urandom;
      r_f3   = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       f_access(r_addr, "rnd_fetch", got);
        1:       d_access(1'b0, r_f3, r_addr, 32'h0, "rnd_load", got);
        default: d_access(1'b1, r_f3, r_addr, r_wd, "rnd_store", got);
      endcase
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
